dat_control_mb: RTL and testbench
=================================

Name: dat_control_mb

Overview:
Parametrised multi-block successor of the DAT-line transfer controller in the SD host.
- Sequences single- or multi-block write/read transfers between the data FIFOs and the DAT physical layer.
- Counts blocks and enforces a per-block data timeout.
- Reports transfer-active, transfer-complete and error status to the register block.
- Sits between the command/register logic (initiation, block count, timeout value) and dat_phys/FIFOs (per-block handshake).

Parameters:
BLKCNT_W, 16, width of block count and blocks_left
TIMEOUT_W, 24, width of timeout reload value and counter

Ports:
host_clk  in  1  host clock; sole clock
rst  in  1  synchronous active-high reset
data_init_tx  in  1  start write transfer (level, sampled in IDLE)
data_init_rx  in  1  start read transfer (level, sampled in IDLE)
multi_blk  in  1  1 = use blk_cnt; 0 = single block
blk_cnt  in  BLKCNT_W  block count, latched at start
timeout_val  in  TIMEOUT_W  per-block timeout in host_clk cycles; 0 = disabled
tx_buf_empty  in  1  TX FIFO empty
rx_buf_full  in  1  RX FIFO full
blk_done  in  1  one-cycle pulse from dat_phys: current block finished
crc_err  in  1  qualifies blk_done: block CRC/status error
abort  in  1  abort request (level)
wr_data_flag  out  1  one-cycle pulse: start write of a block
rd_data_flag  out  1  one-cycle pulse: start read of a block
buf_init_tx  out  1  one-cycle pulse: first block of a write only
buf_init_rx  out  1  one-cycle pulse: first block of a read only
write_tf_active  out  1  write transfer in progress (Present State)
read_tf_active  out  1  read transfer in progress (Present State)
tf_complete  out  1  one-cycle pulse: all blocks done, no error
err_timeout  out  1  one-cycle pulse: data timeout
err_crc  out  1  one-cycle pulse: CRC error reported
aborted  out  1  one-cycle pulse: transfer terminated by abort
blocks_left  out  BLKCNT_W  blocks remaining incl. current

Behaviour:
- Clock and reset: one clock, host_clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE; all outputs 0; blocks_left 0. Reset mid-transfer aborts silently: no pulses, active bits clear next edge.
- States: IDLE, WR_WAIT, RD_WAIT, XFER, NEXT.
- IDLE transitions:
  - data_init_tx & !data_init_rx -> WR_WAIT; write_tf_active<=1.
  - data_init_rx & !data_init_tx -> RD_WAIT; read_tf_active<=1.
  - Both or neither asserted -> stay in IDLE.
  - On start, latch blocks_left = multi_blk ? max(blk_cnt,1) : 1. blk_cnt 0 with multi_blk is treated as 1.
- WR_WAIT: when !tx_buf_empty -> XFER, and on that edge pulse wr_data_flag. Pulse buf_init_tx only if this is the first block. Otherwise stay.
- RD_WAIT: when !rx_buf_full -> XFER, with rd_data_flag and (first block only) buf_init_rx, same as write.
- XFER:
  - Timeout counter loads timeout_val on entry and decrements each cycle.
  - blk_done & crc_err -> IDLE, err_crc pulse.
  - blk_done & !crc_err -> NEXT.
  - Counter reaching 0 without blk_done -> IDLE, err_timeout pulse.
  - blk_done in the same cycle as expiry wins over the timeout.
  - timeout_val 0 means no timeout.
- NEXT: blocks_left decrements.
  - Was 1 -> IDLE, tf_complete pulse.
  - Else -> WR_WAIT or RD_WAIT by direction. Latency blk_done -> next wr/rd_data_flag is ≥2 cycles.
- abort: highest priority in any non-IDLE state -> IDLE next edge, aborted pulse. Suppresses tf_complete and errors that same cycle. Ignored in IDLE.
- Active bits: write_tf_active/read_tf_active clear on the same edge that enters IDLE, for any cause. They are mutually exclusive.
- Inputs held high on return to IDLE: data_init_* still asserted restarts a transfer on the following edge. Initiators must deassert.
- blocks_left holds its final value in IDLE (0 after completion; residual after error or abort).

Decomposition:
- Package dat_ctrl_pkg: state encoding (one-hot, 5 bits), BLKCNT_W/TIMEOUT_W defaults, direction enum (DIR_WR, DIR_RD).
- Sub-module dat_timeout_cnt: load/enable/expired down-counter, TIMEOUT_W wide, zero-load disables.

Test Plan:
- Single write: data_init_tx=1, multi_blk=0, tx_buf_empty 1→0 after 3 cycles, blk_done after 10 -> one wr_data_flag + buf_init_tx, tf_complete one cycle after NEXT, write_tf_active high throughout and clears on that edge.
- Multi read: blk_cnt=3, multi_blk=1, rx_buf_full=0, three blk_done pulses -> rd_data_flag ×3, buf_init_rx ×1, blocks_left 3→2→1→0, single tf_complete.
- Timeout: timeout_val=5, no blk_done -> err_timeout 5 cycles after XFER entry, no tf_complete, read_tf_active=0. Repeat with blk_done on expiry cycle -> no error.
- CRC: blk_cnt=2, first blk_done with crc_err=1 -> err_crc, IDLE, blocks_left=2.
- Abort mid-XFER of block 2 of 4 -> aborted next edge, blocks_left=3, active bits 0. Abort coincident with final blk_done -> aborted only.
- Start conflicts: data_init_tx=data_init_rx=1 -> stays IDLE. blk_cnt=0, multi_blk=1 -> exactly one block, then tf_complete.

Source files
------------

// File: rtl/dat_ctrl_pkg.sv
// Shared definitions for the multi-block DAT transfer controller:
// one-hot state encoding, default widths and transfer direction.
package dat_ctrl_pkg;

  localparam int BLKCNT_W_DEF  = 16;
  localparam int TIMEOUT_W_DEF = 24;
  localparam int STATE_W       = 5;

  localparam logic [STATE_W-1:0] S_IDLE    = 5'b00001;
  localparam logic [STATE_W-1:0] S_WR_WAIT = 5'b00010;
  localparam logic [STATE_W-1:0] S_RD_WAIT = 5'b00100;
  localparam logic [STATE_W-1:0] S_XFER    = 5'b01000;
  localparam logic [STATE_W-1:0] S_NEXT    = 5'b10000;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_e;

endpackage

// File: rtl/dat_timeout_cnt.sv
// Per-block data timeout down-counter. A zero load value leaves the
// counter idle at zero, so it never expires.
module dat_timeout_cnt #(
  parameter int TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [TIMEOUT_W-1:0] load_val,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - TIMEOUT_W'(1);
    end
  end

  // Flags the cycle whose edge would take the count to zero.
  assign expired = en && (cnt == TIMEOUT_W'(1));

endmodule

// File: rtl/dat_control_mb.sv
// Multi-block DAT-line transfer controller: sequences write/read blocks
// between the data FIFOs and dat_phys, with block counting and timeout.
module dat_control_mb
  import dat_ctrl_pkg::*;
#(
  parameter int BLKCNT_W  = BLKCNT_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
  input  logic                 host_clk,
  input  logic                 rst,
  input  logic                 data_init_tx,
  input  logic                 data_init_rx,
  input  logic                 multi_blk,
  input  logic [BLKCNT_W-1:0]  blk_cnt,
  input  logic [TIMEOUT_W-1:0] timeout_val,
  input  logic                 tx_buf_empty,
  input  logic                 rx_buf_full,
  input  logic                 blk_done,
  input  logic                 crc_err,
  input  logic                 abort,
  output logic                 wr_data_flag,
  output logic                 rd_data_flag,
  output logic                 buf_init_tx,
  output logic                 buf_init_rx,
  output logic                 write_tf_active,
  output logic                 read_tf_active,
  output logic                 tf_complete,
  output logic                 err_timeout,
  output logic                 err_crc,
  output logic                 aborted,
  output logic [BLKCNT_W-1:0]  blocks_left
);

  logic [STATE_W-1:0]  state, state_nxt;
  dir_e                dir, dir_nxt;
  logic                first_blk, first_nxt;
  logic [BLKCNT_W-1:0] blocks_nxt;
  logic                wr_flag_nxt, rd_flag_nxt, binit_tx_nxt, binit_rx_nxt;
  logic                done_nxt, to_nxt, crc_nxt, abort_nxt;
  logic                tmr_load, tmr_expired;

  // A multi-block request for zero blocks still moves one block.
  function automatic logic [BLKCNT_W-1:0] start_count(input logic multi,
                                                      input logic [BLKCNT_W-1:0] cnt);
    if (!multi || cnt == '0) return BLKCNT_W'(1);
    return cnt;
  endfunction

  dat_timeout_cnt #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .clk      (host_clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (state == S_XFER),
    .load_val (timeout_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_nxt    = state;
    dir_nxt      = dir;
    first_nxt    = first_blk;
    blocks_nxt   = blocks_left;
    wr_flag_nxt  = 1'b0;
    rd_flag_nxt  = 1'b0;
    binit_tx_nxt = 1'b0;
    binit_rx_nxt = 1'b0;
    done_nxt     = 1'b0;
    to_nxt       = 1'b0;
    crc_nxt      = 1'b0;
    abort_nxt    = 1'b0;
    tmr_load     = 1'b0;
    // Abort outranks every other event once a transfer is under way.
    if (state != S_IDLE && abort) begin
      state_nxt = S_IDLE;
      abort_nxt = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (data_init_tx && !data_init_rx) begin
            state_nxt  = S_WR_WAIT;
            dir_nxt    = DIR_WR;
            first_nxt  = 1'b1;
            blocks_nxt = start_count(multi_blk, blk_cnt);
          end else if (data_init_rx && !data_init_tx) begin
            state_nxt  = S_RD_WAIT;
            dir_nxt    = DIR_RD;
            first_nxt  = 1'b1;
            blocks_nxt = start_count(multi_blk, blk_cnt);
          end
        end
        S_WR_WAIT: begin
          if (!tx_buf_empty) begin
            state_nxt    = S_XFER;
            wr_flag_nxt  = 1'b1;
            binit_tx_nxt = first_blk;
            first_nxt    = 1'b0;
            tmr_load     = 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (!rx_buf_full) begin
            state_nxt    = S_XFER;
            rd_flag_nxt  = 1'b1;
            binit_rx_nxt = first_blk;
            first_nxt    = 1'b0;
            tmr_load     = 1'b1;
          end
        end
        S_XFER: begin
          if (blk_done && crc_err) begin
            state_nxt = S_IDLE;
            crc_nxt   = 1'b1;
          end else if (blk_done) begin
            state_nxt = S_NEXT;
          end else if (tmr_expired) begin
            state_nxt = S_IDLE;
            to_nxt    = 1'b1;
          end
        end
        S_NEXT: begin
          blocks_nxt = blocks_left - BLKCNT_W'(1);
          if (blocks_left == BLKCNT_W'(1)) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = (dir == DIR_WR) ? S_WR_WAIT : S_RD_WAIT;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge host_clk) begin
    if (rst) begin
      state           <= S_IDLE;
      dir             <= DIR_WR;
      first_blk       <= 1'b0;
      blocks_left     <= '0;
      wr_data_flag    <= 1'b0;
      rd_data_flag    <= 1'b0;
      buf_init_tx     <= 1'b0;
      buf_init_rx     <= 1'b0;
      write_tf_active <= 1'b0;
      read_tf_active  <= 1'b0;
      tf_complete     <= 1'b0;
      err_timeout     <= 1'b0;
      err_crc         <= 1'b0;
      aborted         <= 1'b0;
    end else begin
      state           <= state_nxt;
      dir             <= dir_nxt;
      first_blk       <= first_nxt;
      blocks_left     <= blocks_nxt;
      wr_data_flag    <= wr_flag_nxt;
      rd_data_flag    <= rd_flag_nxt;
      buf_init_tx     <= binit_tx_nxt;
      buf_init_rx     <= binit_rx_nxt;
      write_tf_active <= (state_nxt != S_IDLE) && (dir_nxt == DIR_WR);
      read_tf_active  <= (state_nxt != S_IDLE) && (dir_nxt == DIR_RD);
      tf_complete     <= done_nxt;
      err_timeout     <= to_nxt;
      err_crc         <= crc_nxt;
      aborted         <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_dat_control_mb.sv
// Scoreboard bench for dat_control_mb: directed transfers push expected
// pulse events; a monitor pops and compares whenever a pulse appears.
module tb_dat_control_mb;

  localparam logic [7:0] P_WR   = 8'h80;
  localparam logic [7:0] P_RD   = 8'h40;
  localparam logic [7:0] P_BTX  = 8'h20;
  localparam logic [7:0] P_BRX  = 8'h10;
  localparam logic [7:0] P_DONE = 8'h08;
  localparam logic [7:0] P_TO   = 8'h04;
  localparam logic [7:0] P_CRC  = 8'h02;
  localparam logic [7:0] P_AB   = 8'h01;

  logic        host_clk = 1'b0;
  logic        rst, data_init_tx, data_init_rx, multi_blk;
  logic [15:0] blk_cnt;
  logic [23:0] timeout_val;
  logic        tx_buf_empty, rx_buf_full, blk_done, crc_err, abort;
  logic        wr_data_flag, rd_data_flag, buf_init_tx, buf_init_rx;
  logic        write_tf_active, read_tf_active, tf_complete;
  logic        err_timeout, err_crc, aborted;
  logic [15:0] blocks_left;

  dat_control_mb dut (
    .host_clk        (host_clk),
    .rst             (rst),
    .data_init_tx    (data_init_tx),
    .data_init_rx    (data_init_rx),
    .multi_blk       (multi_blk),
    .blk_cnt         (blk_cnt),
    .timeout_val     (timeout_val),
    .tx_buf_empty    (tx_buf_empty),
    .rx_buf_full     (rx_buf_full),
    .blk_done        (blk_done),
    .crc_err         (crc_err),
    .abort           (abort),
    .wr_data_flag    (wr_data_flag),
    .rd_data_flag    (rd_data_flag),
    .buf_init_tx     (buf_init_tx),
    .buf_init_rx     (buf_init_rx),
    .write_tf_active (write_tf_active),
    .read_tf_active  (read_tf_active),
    .tf_complete     (tf_complete),
    .err_timeout     (err_timeout),
    .err_crc         (err_crc),
    .aborted         (aborted),
    .blocks_left     (blocks_left)
  );

  always #5 host_clk = ~host_clk;

  typedef struct {
    logic [7:0]  pulses;
    logic [15:0] bl;
    logic [1:0]  act;
    int          gap;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  always @(posedge host_clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge host_clk);
  endtask

  task automatic push(input logic [7:0] p, input int bl, input logic [1:0] act, input int gap);
    ev_t e;
    e.pulses = p;
    e.bl     = 16'(bl);
    e.act    = act;
    e.gap    = gap;
    q.push_back(e);
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge host_clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d events outstanding, required 0", name, q.size());
      q.delete();
    end
    tick(2);
  endtask

  // Monitor: one scoreboard comparison per cycle that shows any pulse.
  initial begin
    logic [7:0] pulses;
    ev_t        e;
    int         g;
    int         last_cyc = 0;
    forever begin
      @(posedge host_clk);
      #1;
      pulses = {wr_data_flag, rd_data_flag, buf_init_tx, buf_init_rx,
                tf_complete, err_timeout, err_crc, aborted};
      if (pulses != 8'h00) begin
        checks++;
        g = cyc - last_cyc;
        last_cyc = cyc;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got pulses=%b blocks_left=%0d, required no event",
                   pulses, blocks_left);
        end else begin
          e = q.pop_front();
          if (pulses !== e.pulses || blocks_left !== e.bl ||
              {write_tf_active, read_tf_active} !== e.act || (e.gap >= 0 && g != e.gap)) begin
            errors++;
            $display("FAIL event: got pulses=%b bl=%0d act=%b gap=%0d, required pulses=%b bl=%0d act=%b gap=%0d",
                     pulses, blocks_left, {write_tf_active, read_tf_active}, g,
                     e.pulses, e.bl, e.act, e.gap);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; data_init_tx = 1'b0; data_init_rx = 1'b0; multi_blk = 1'b0;
    blk_cnt = '0; timeout_val = '0; tx_buf_empty = 1'b1; rx_buf_full = 1'b1;
    blk_done = 1'b0; crc_err = 1'b0; abort = 1'b0;
    tick(3);
    check_val("reset_outputs_in_reset", int'({wr_data_flag, rd_data_flag, buf_init_tx, buf_init_rx,
              write_tf_active, read_tf_active, tf_complete, err_timeout, err_crc, aborted,
              blocks_left}), 0);
    rst = 1'b0;
    tick(2);
    check_val("reset_outputs_after", int'({write_tf_active, read_tf_active, blocks_left}), 0);

    // Single-block write; FIFO becomes non-empty 3 cycles after start.
    push(P_WR | P_BTX, 1, 2'b10, -1);
    push(P_DONE, 0, 2'b00, 11);
    multi_blk = 1'b0; blk_cnt = 16'd5; data_init_tx = 1'b1;
    tick(1); data_init_tx = 1'b0;
    tick(2); tx_buf_empty = 1'b0;
    tick(5);
    check_val("single_wr_active_mid", int'({write_tf_active, read_tf_active}), 2);
    tick(5); blk_done = 1'b1;
    tick(1); blk_done = 1'b0;
    drain("single_wr", 40);

    // Three-block read.
    push(P_RD | P_BRX, 3, 2'b01, -1);
    push(P_RD, 2, 2'b01, 6);
    push(P_RD, 1, 2'b01, 5);
    push(P_DONE, 0, 2'b00, 4);
    rx_buf_full = 1'b0; multi_blk = 1'b1; blk_cnt = 16'd3; data_init_rx = 1'b1;
    tick(1); data_init_rx = 1'b0;
    for (int b = 0; b < 3; b++) begin
      tick(4); blk_done = 1'b1;
      tick(1); blk_done = 1'b0;
    end
    drain("multi_rd", 40);

    // Timeout of 5 with no blk_done, then blk_done on the expiry cycle.
    timeout_val = 24'd5; multi_blk = 1'b0;
    push(P_RD | P_BRX, 1, 2'b01, -1);
    push(P_TO, 1, 2'b00, 5);
    data_init_rx = 1'b1;
    tick(1); data_init_rx = 1'b0;
    drain("timeout", 40);
    push(P_RD | P_BRX, 1, 2'b01, -1);
    push(P_DONE, 0, 2'b00, 6);
    data_init_rx = 1'b1;
    tick(1); data_init_rx = 1'b0;
    tick(5); blk_done = 1'b1;
    tick(1); blk_done = 1'b0;
    drain("timeout_race", 40);
    timeout_val = '0;

    // CRC error on first block of two.
    push(P_WR | P_BTX, 2, 2'b10, -1);
    push(P_CRC, 2, 2'b00, 2);
    tx_buf_empty = 1'b0; multi_blk = 1'b1; blk_cnt = 16'd2; data_init_tx = 1'b1;
    tick(1); data_init_tx = 1'b0;
    tick(2); blk_done = 1'b1; crc_err = 1'b1;
    tick(1); blk_done = 1'b0; crc_err = 1'b0;
    drain("crc", 40);

    // Abort during block 2 of 4.
    push(P_WR | P_BTX, 4, 2'b10, -1);
    push(P_WR, 3, 2'b10, 4);
    push(P_AB, 3, 2'b00, 2);
    blk_cnt = 16'd4; data_init_tx = 1'b1;
    tick(1); data_init_tx = 1'b0;
    tick(2); blk_done = 1'b1;
    tick(1); blk_done = 1'b0;
    tick(3); abort = 1'b1;
    tick(1); abort = 1'b0;
    drain("abort_mid", 40);

    // Abort coincident with the final blk_done.
    push(P_WR | P_BTX, 1, 2'b10, -1);
    push(P_AB, 1, 2'b00, 2);
    multi_blk = 1'b0; data_init_tx = 1'b1;
    tick(1); data_init_tx = 1'b0;
    tick(2); blk_done = 1'b1; abort = 1'b1;
    tick(1); blk_done = 1'b0; abort = 1'b0;
    drain("abort_last", 40);

    // Conflicting starts and abort while idle do nothing.
    data_init_tx = 1'b1; data_init_rx = 1'b1;
    tick(3);
    data_init_tx = 1'b0; data_init_rx = 1'b0; abort = 1'b1;
    tick(2); abort = 1'b0;
    tick(1);
    check_val("conflict_active", int'({write_tf_active, read_tf_active}), 0);
    check_val("conflict_blocks_left", int'(blocks_left), 1);

    // Multi-block with a zero count moves exactly one block.
    push(P_RD | P_BRX, 1, 2'b01, -1);
    push(P_DONE, 0, 2'b00, 3);
    multi_blk = 1'b1; blk_cnt = 16'd0; data_init_rx = 1'b1;
    tick(1); data_init_rx = 1'b0;
    tick(2); blk_done = 1'b1;
    tick(1); blk_done = 1'b0;
    drain("zero_cnt", 40);

    // Reset in the middle of a transfer clears silently.
    push(P_WR | P_BTX, 3, 2'b10, -1);
    blk_cnt = 16'd3; data_init_tx = 1'b1;
    tick(1); data_init_tx = 1'b0;
    tick(2); rst = 1'b1;
    tick(1); rst = 1'b0;
    check_val("reset_mid_status", int'({write_tf_active, read_tf_active, blocks_left}), 0);
    tick(3);
    drain("reset_mid", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
